// File: rtl/seq_detect_session_ctrl.sv
// Session controller for the tolerant shift-register pattern detector:
// holds detector config, runs warm-up, counts hits until limit/timeout/abort.
module seq_detect_session_ctrl #(
  parameter int                 WIDTH       = 6,
  parameter int                 TOL_W       = 3,
  parameter int                 CNT_W       = 8,
  parameter int                 TMO_W       = 16,
  parameter logic [WIDTH-1:0]   DEF_PATTERN = 6'b101001,
  parameter logic [TOL_W-1:0]   DEF_TOL     = 3'd2
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [WIDTH-1:0] i_cfg_pattern,
  input  logic [TOL_W-1:0] i_cfg_tol,
  input  logic [CNT_W-1:0] i_cfg_hit_limit,
  input  logic [TMO_W-1:0] i_cfg_timeout,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_data_valid,
  output logic             o_det_en,
  output logic             o_det_clr,
  output logic [WIDTH-1:0] o_det_pattern,
  output logic [TOL_W-1:0] o_det_tol,
  input  logic             i_det_hit,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_status,
  output logic [CNT_W-1:0] o_hit_count
);

  // state  | meaning
  // IDLE   | no session yet; config accepted
  // WARMUP | detector filling; counting WIDTH valid bits, hits ignored
  // SEARCH | counting hits and valid bits toward limit / timeout
  // DONE   | session ended; count and status held; config accepted
  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_SEARCH, ST_DONE} state_e;

  localparam int                WARM_W    = $clog2(WIDTH + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [TOL_W-1:0]   tol_q, tol_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [TMO_W-1:0]   timeout_q, timeout_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [1:0]         status_q, status_d;
  logic               done_q, done_d;
  logic               clr_q, clr_d;
  logic               first_q, first_d;

  logic active, hit_inc, limit_hit, tmo_hit;

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    tol_d      = tol_q;
    limit_d    = limit_q;
    timeout_d  = timeout_q;
    warm_cnt_d = warm_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    status_d   = status_q;
    done_d     = 1'b0;
    clr_d      = 1'b0;
    first_d    = 1'b0;
    hit_inc    = 1'b0;
    limit_hit  = 1'b0;
    tmo_hit    = 1'b0;
    active     = (state_q == ST_WARMUP) || (state_q == ST_SEARCH);

    if (i_cfg_valid && !active) begin
      pattern_d = i_cfg_pattern;
      tol_d     = i_cfg_tol;
      limit_d   = i_cfg_hit_limit;
      timeout_d = i_cfg_timeout;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d    = ST_WARMUP;
          clr_d      = 1'b1;
          hit_cnt_d  = '0;
          status_d   = 2'b00;
          warm_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end
      ST_WARMUP: begin
        if (i_data_valid) begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d = ST_SEARCH;
            first_d = 1'b1;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end
      end
      ST_SEARCH: begin
        // the detector's registered flag still reflects warm-up data on the first cycle
        hit_inc = i_det_hit && !first_q;
        if (hit_inc && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        if (i_data_valid) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        limit_hit = hit_inc && (limit_q != '0) && (hit_cnt_d == limit_q);
        tmo_hit   = i_data_valid && (timeout_q != '0) && (tmo_cnt_d == timeout_q);
        if (limit_hit) begin
          state_d  = ST_DONE;
          status_d = 2'b01;
          done_d   = 1'b1;
        end else if (tmo_hit) begin
          state_d  = ST_DONE;
          status_d = 2'b10;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && i_abort) begin
      state_d  = ST_DONE;
      status_d = 2'b11;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= ST_IDLE;
      pattern_q  <= DEF_PATTERN;
      tol_q      <= DEF_TOL;
      limit_q    <= '0;
      timeout_q  <= '0;
      warm_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      status_q   <= 2'b00;
      done_q     <= 1'b0;
      clr_q      <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      tol_q      <= tol_d;
      limit_q    <= limit_d;
      timeout_q  <= timeout_d;
      warm_cnt_q <= warm_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      status_q   <= status_d;
      done_q     <= done_d;
      clr_q      <= clr_d;
      first_q    <= first_d;
    end
  end

  assign o_cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign o_busy        = (state_q == ST_WARMUP) || (state_q == ST_SEARCH);
  assign o_det_en      = o_busy && i_data_valid;
  assign o_det_clr     = clr_q;
  assign o_det_pattern = pattern_q;
  assign o_det_tol     = tol_q;
  assign o_done        = done_q;
  assign o_status      = status_q;
  assign o_hit_count   = hit_cnt_q;

endmodule

// File: tb/tb_seq_detect_session_ctrl.sv
// Self-checking bench for seq_detect_session_ctrl; session results go through
// a queue filled at start and drained on each o_done pulse.
module tb_seq_detect_session_ctrl;

  logic       clk, resetn;
  logic       cfg_valid, cfg_ready;
  logic [5:0] cfg_pattern;
  logic [2:0] cfg_tol;
  logic [7:0] cfg_hit_limit;
  logic [15:0] cfg_timeout;
  logic       start, abort, data_valid, det_en, det_clr, det_hit, busy, done;
  logic [5:0] det_pattern;
  logic [2:0] det_tol;
  logic [1:0] status;
  logic [7:0] hit_count;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] sb_exp;

  seq_detect_session_ctrl dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_pattern(cfg_pattern), .i_cfg_tol(cfg_tol),
    .i_cfg_hit_limit(cfg_hit_limit), .i_cfg_timeout(cfg_timeout),
    .i_start(start), .i_abort(abort), .i_data_valid(data_valid),
    .o_det_en(det_en), .o_det_clr(det_clr),
    .o_det_pattern(det_pattern), .o_det_tol(det_tol),
    .i_det_hit(det_hit), .o_busy(busy), .o_done(done),
    .o_status(status), .o_hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: each completion pops the result expected for that session
  always @(negedge clk) begin
    if (resetn && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: status=%b count=%0d, none expected", status, hit_count);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({status, hit_count} !== sb_exp) begin
          errors++;
          $display("FAIL sb_result: got status=%b count=%0d, expected status=%b count=%0d",
                   status, hit_count, sb_exp[9:8], sb_exp[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [5:0] pat, input logic [2:0] tol,
                               input logic [7:0] lim, input logic [15:0] tmo);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_tol = tol;
    cfg_hit_limit = lim; cfg_timeout = tmo; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    checks++; if (det_clr !== 1'b1) begin errors++; $display("FAIL start_clr: got %b expected 1", det_clr); end
    checks++; if (det_pattern !== pat) begin errors++; $display("FAIL start_pattern: got %b expected %b", det_pattern, pat); end
    checks++; if (det_tol !== tol) begin errors++; $display("FAIL start_tol: got %0d expected %0d", det_tol, tol); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    tick();
    checks++; if (det_clr !== 1'b0) begin errors++; $display("FAIL clr_single: got %b expected 0", det_clr); end
  endtask

  task automatic warmup(input logic hit);
    data_valid = 1'b1; det_hit = hit;
    repeat (6) tick();
    data_valid = 1'b0; det_hit = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; data_valid = 1'b1;
    #12;
    checks++; if (det_pattern !== 6'b101001) begin errors++; $display("FAIL rst_pattern: got %b expected 101001", det_pattern); end
    checks++; if (det_tol !== 3'd2) begin errors++; $display("FAIL rst_tol: got %0d expected 2", det_tol); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL rst_status: got %b expected 00", status); end
    checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", hit_count); end
    checks++; if ({done, det_clr, det_en} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b expected 000", {done, det_clr, det_en}); end
    data_valid = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_limit();
    exp_q.push_back({2'b01, 8'd3});
    start_session(6'b110011, 3'd1, 8'd3, 16'd0);
    warmup(1'b0);
    tick();
    det_hit = 1'b1;
    repeat (2) tick();
    checks++; if (done !== 1'b0 || hit_count !== 8'd2) begin errors++; $display("FAIL limit_mid: got done=%b count=%0d expected done=0 count=2", done, hit_count); end
    tick();
    det_hit = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL limit_done: got %b expected 1", done); end
    checks++; if (status !== 2'b01 || hit_count !== 8'd3) begin errors++; $display("FAIL limit_result: got status=%b count=%0d expected 01/3", status, hit_count); end
    checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL limit_idle: got ready=%b busy=%b expected 1/0", cfg_ready, busy); end
    tick();
    checks++; if (done !== 1'b0 || status !== 2'b01 || hit_count !== 8'd3) begin errors++; $display("FAIL limit_hold: got done=%b status=%b count=%0d expected 0/01/3", done, status, hit_count); end
  endtask

  task automatic test_timeout();
    int  nvalid = 0;
    bit  fin = 1'b0;
    logic vld, exp_done;
    exp_q.push_back({2'b10, 8'd0});
    start_session(6'b111000, 3'd2, 8'd0, 16'd20);
    for (int c = 0; c < 400 && !fin; c++) begin
      vld = ($urandom_range(0, 3) != 0);
      data_valid = vld;
      tick();
      if (vld) nvalid++;
      exp_done = vld && (nvalid == 26);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL tmo_done: got %b expected %b after %0d valid bits", done, exp_done, nvalid);
      end
      if (done || exp_done) fin = 1'b1;
    end
    data_valid = 1'b0;
    if (!fin) begin checks++; errors++; $display("FAIL tmo_budget: got no completion, expected done after 26 valid bits"); end
    checks++; if (status !== 2'b10 || hit_count !== 8'd0) begin errors++; $display("FAIL tmo_result: got status=%b count=%0d expected 10/0", status, hit_count); end
  endtask

  task automatic test_hit_filter();
    exp_q.push_back({2'b01, 8'd1});
    start_session(6'b001101, 3'd3, 8'd1, 16'd3);
    warmup(1'b1);
    checks++; if (hit_count !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL warm_hits: got count=%0d busy=%b expected 0/1", hit_count, busy); end
    data_valid = 1'b1; det_hit = 1'b1;
    tick();
    checks++; if (hit_count !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL first_search_hit: got count=%0d busy=%b expected 0/1", hit_count, busy); end
    det_hit = 1'b0;
    tick();
    det_hit = 1'b1;
    tick();
    det_hit = 1'b0; data_valid = 1'b0;
    checks++; if (done !== 1'b1 || status !== 2'b01 || hit_count !== 8'd1) begin errors++; $display("FAIL limit_over_tmo: got done=%b status=%b count=%0d expected 1/01/1", done, status, hit_count); end
  endtask

  task automatic test_cfg_hold_abort();
    exp_q.push_back({2'b11, 8'd0});
    start_session(6'b011110, 3'd4, 8'd0, 16'd0);
    data_valid = 1'b1;
    repeat (2) tick();
    cfg_valid = 1'b1; cfg_pattern = 6'b000111; cfg_tol = 3'd7;
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    checks++; if (det_pattern !== 6'b011110 || det_tol !== 3'd4) begin errors++; $display("FAIL cfg_hold: got %b/%0d expected 011110/4", det_pattern, det_tol); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || status !== 2'b11) begin errors++; $display("FAIL abort_done: got done=%b status=%b expected 1/11", done, status); end
    checks++; if (det_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_gating: got en=%b busy=%b ready=%b expected 0/0/1", det_en, busy, cfg_ready); end
    data_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b0 || status !== 2'b11) begin errors++; $display("FAIL abort_in_done: got done=%b status=%b expected 0/11", done, status); end
  endtask

  task automatic test_saturate();
    exp_q.push_back({2'b11, 8'd255});
    start_session(6'b100110, 3'd2, 8'd0, 16'd0);
    warmup(1'b0);
    tick();
    det_hit = 1'b1;
    repeat (300) tick();
    det_hit = 1'b0;
    checks++; if (hit_count !== 8'd255 || busy !== 1'b1) begin errors++; $display("FAIL saturate: got count=%0d busy=%b expected 255/1", hit_count, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL sat_abort: got status=%b expected 11", status); end
  endtask

  task automatic test_reset_mid();
    start_session(6'b010101, 3'd1, 8'd0, 16'd0);
    warmup(1'b0);
    tick();
    det_hit = 1'b1;
    repeat (5) tick();
    det_hit = 1'b0;
    checks++; if (hit_count !== 8'd5) begin errors++; $display("FAIL mid_count: got %0d expected 5", hit_count); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (det_clr !== 1'b0 || hit_count !== 8'd5 || busy !== 1'b1) begin errors++; $display("FAIL start_ignored: got clr=%b count=%0d busy=%b expected 0/5/1", det_clr, hit_count, busy); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_state: got busy=%b ready=%b expected 0/1", busy, cfg_ready); end
    checks++; if (hit_count !== 8'd0 || status !== 2'b00) begin errors++; $display("FAIL mid_rst_count: got count=%0d status=%b expected 0/00", hit_count, status); end
    checks++; if (det_pattern !== 6'b101001 || det_tol !== 3'd2) begin errors++; $display("FAIL mid_rst_cfg: got %b/%0d expected 101001/2", det_pattern, det_tol); end
    #1 resetn = 1'b1;
    tick();
    checks++; if (det_pattern !== 6'b101001 || busy !== 1'b0) begin errors++; $display("FAIL post_rst: got pattern=%b busy=%b expected 101001/0", det_pattern, busy); end
  endtask

  initial begin
    cfg_valid = 1'b0; cfg_pattern = '0; cfg_tol = '0; cfg_hit_limit = '0; cfg_timeout = '0;
    start = 1'b0; abort = 1'b0; data_valid = 1'b0; det_hit = 1'b0; resetn = 1'b0;
    test_reset();
    test_limit();
    test_timeout();
    test_hit_filter();
    test_cfg_hold_abort();
    test_saturate();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending results expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
